ddr_axi_arbiter: RTL and testbench

// Round-robin arbiter sharing one Pango DDR AXI user port (256-bit data, 28-bit address) among NUM_REQ masters.

---
 rtl/ddr_axi_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_ddr_axi_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_axi_arbiter.sv
// Round-robin arbiter sharing one DDR AXI user port among NUM_REQ masters.
// One write or read burst is outstanding at a time; the owner index drives the AXI user ID fields.
module ddr_axi_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*28-1:0]  req_addr,
  input  logic [NUM_REQ*4-1:0]   req_len,
  input  logic [NUM_REQ*256-1:0] req_wdata,
  output logic [NUM_REQ-1:0]     req_wbeat,
  output logic [255:0]           rsp_rdata,
  output logic [NUM_REQ-1:0]     rsp_rvalid,
  output logic [NUM_REQ-1:0]     rsp_rlast,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic [27:0]            axi_awaddr,
  output logic                   axi_awuser_ap,
  output logic [3:0]             axi_awuser_id,
  output logic [3:0]             axi_awlen,
  output logic                   axi_awvalid,
  input  logic                   axi_awready,
  output logic [255:0]           axi_wdata,
  output logic [31:0]            axi_wstrb,
  input  logic                   axi_wready,
  input  logic                   axi_wusero_last,
  output logic [27:0]            axi_araddr,
  output logic                   axi_aruser_ap,
  output logic [3:0]             axi_aruser_id,
  output logic [3:0]             axi_arlen,
  output logic                   axi_arvalid,
  input  logic                   axi_arready,
  input  logic [255:0]           axi_rdata,
  input  logic [3:0]             axi_rid,
  input  logic                   axi_rlast,
  input  logic                   axi_rvalid
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned AW    = 28;
  localparam int unsigned LW    = 4;
  localparam int unsigned DW    = 256;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_WDATA, S_AR, S_RDATA} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d, ptr_q, ptr_d, winner;
  logic [AW-1:0]      addr_q, addr_d, sel_addr;
  logic [LW-1:0]      len_q, len_d, sel_len, beat_q, beat_d;
  logic               wlast_q, wlast_d, sel_write, found;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] done_q, done_d, owner_oh, winner_oh;
  int unsigned        best_dist;

  // Winner is the valid requester closest after ptr_q in rotating order
  always_comb begin
    winner    = ptr_q;
    best_dist = NUM_REQ;
    sel_addr  = '0;
    sel_len   = '0;
    sel_write = 1'b0;
    axi_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (((i + NUM_REQ - 1 - 32'(ptr_q)) % NUM_REQ) < best_dist)) begin
        best_dist = (i + NUM_REQ - 1 - 32'(ptr_q)) % NUM_REQ;
        winner    = IDX_W'(i);
      end
    end
    found = (best_dist < NUM_REQ);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_addr  = req_addr[i*AW +: AW];
        sel_len   = req_len[i*LW +: LW];
        sel_write = req_write[i];
      end
      if (owner_q == IDX_W'(i)) begin
        axi_wdata = req_wdata[i*DW +: DW];
      end
    end
    winner_oh = NUM_REQ'(1) << winner;
    owner_oh  = NUM_REQ'(1) << owner_q;
  end

  // Burst sequencing: next state, latched command and per-owner strobes
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    wlast_d    = wlast_q;
    err_d      = err_q;
    done_d     = '0;
    req_ready  = '0;
    req_wbeat  = '0;
    rsp_rvalid = '0;
    rsp_rlast  = '0;
    case (state_q)
      S_IDLE: begin
        beat_d  = '0;
        wlast_d = 1'b0;
        if (found) begin
          req_ready = winner_oh;
          owner_d   = winner;
          ptr_d     = winner;
          addr_d    = sel_addr;
          len_d     = sel_len;
          state_d   = sel_write ? S_AW : S_AR;
        end
      end
      S_AW: begin
        if (axi_wready) begin
          req_wbeat = owner_oh;
          beat_d    = beat_q + 4'd1;
        end
        if (axi_wusero_last) wlast_d = 1'b1;
        // Controller may finish all write beats before accepting the address
        if (axi_awready) begin
          if (wlast_q || axi_wusero_last) begin
            done_d  = owner_oh;
            state_d = S_IDLE;
          end else begin
            state_d = S_WDATA;
          end
        end
      end
      S_WDATA: begin
        if (axi_wready) begin
          req_wbeat = owner_oh;
          beat_d    = beat_q + 4'd1;
        end
        if (axi_wusero_last) begin
          done_d  = owner_oh;
          state_d = S_IDLE;
        end
      end
      S_AR: begin
        if (axi_arready) state_d = S_RDATA;
      end
      S_RDATA: begin
        rsp_rvalid = axi_rvalid ? owner_oh : '0;
        rsp_rlast  = axi_rlast  ? owner_oh : '0;
        if (axi_rvalid && (axi_rid != 4'(owner_q))) err_d = 1'b1;
        if (axi_rvalid && axi_rlast) begin
          done_d  = owner_oh;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      wlast_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wlast_q <= wlast_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign axi_awvalid   = (state_q == S_AW);
  assign axi_arvalid   = (state_q == S_AR);
  assign axi_awaddr    = addr_q;
  assign axi_araddr    = addr_q;
  assign axi_awlen     = len_q;
  assign axi_arlen     = len_q;
  assign axi_awuser_id = 4'(owner_q);
  assign axi_aruser_id = 4'(owner_q);
  assign axi_awuser_ap = 1'b1;
  assign axi_aruser_ap = 1'b1;
  assign axi_wstrb     = '1;
  assign rsp_rdata     = axi_rdata;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ddr_axi_arbiter.sv
// Bench for ddr_axi_arbiter: randomized bursts checked against a burst-level round-robin model.
module tb_ddr_axi_arbiter;

  localparam int unsigned NR = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready, req_write, req_wbeat;
  logic [NR*28-1:0]  req_addr;
  logic [NR*4-1:0]   req_len;
  logic [NR*256-1:0] req_wdata;
  logic [255:0]      rsp_rdata, axi_wdata, axi_rdata;
  logic [NR-1:0]     rsp_rvalid, rsp_rlast, done;
  logic              err;
  logic [27:0]       axi_awaddr, axi_araddr;
  logic              axi_awuser_ap, axi_aruser_ap, axi_awvalid, axi_arvalid;
  logic [3:0]        axi_awuser_id, axi_aruser_id, axi_awlen, axi_arlen, axi_rid;
  logic              axi_awready, axi_wready, axi_wusero_last, axi_arready, axi_rlast, axi_rvalid;
  logic [31:0]       axi_wstrb;

  logic [255:0] wd [NR];
  logic [27:0]  ad [NR];
  logic [3:0]   ln [NR];
  assign req_wdata = {wd[1], wd[0]};
  assign req_addr  = {ad[1], ad[0]};
  assign req_len   = {ln[1], ln[0]};

  int passed = 0;
  int total  = 0;
  logic       m_ptr;
  logic       m_err;
  logic [1:0] obs_grant;

  always #5 clk = ~clk;

  ddr_axi_arbiter #(.NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .req_wbeat(req_wbeat), .rsp_rdata(rsp_rdata), .rsp_rvalid(rsp_rvalid),
    .rsp_rlast(rsp_rlast), .done(done), .err(err),
    .axi_awaddr(axi_awaddr), .axi_awuser_ap(axi_awuser_ap), .axi_awuser_id(axi_awuser_id),
    .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
    .axi_wusero_last(axi_wusero_last),
    .axi_araddr(axi_araddr), .axi_aruser_ap(axi_aruser_ap), .axi_aruser_id(axi_aruser_id),
    .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rid(axi_rid), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid)
  );

  function automatic logic [255:0] r256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  // One complete burst: grant from the model, address phase, beats, completion.
  // abort_beat >= 0 asserts rst right after that write beat. aw_wait < 0 picks a random stall.
  task automatic do_burst(input logic [1:0] vm, input bit bad_rid, input int abort_beat,
                          input int aw_wait);
    logic       own;
    logic [1:0] oh;
    logic [1:0] exp_rl;
    logic [3:0] exp_id;
    logic [255:0] d;
    int n, w;
    own       = vm[~m_ptr] ? ~m_ptr : m_ptr;
    oh        = 2'b01 << own;
    exp_id    = {3'b000, own};
    req_valid = vm;
    #1;
    n = 0;
    while (req_ready === 2'b00 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    obs_grant = req_ready;
    total++;
    if (req_ready !== oh) begin
      $display("FAIL grant: req_ready=%b expected %b", req_ready, oh);
      req_valid = '0;
      return;
    end else passed++;
    m_ptr = own;
    @(negedge clk);
    req_valid[own] = 1'b0;
    #1;
    total++;
    if (done !== 2'b00) $display("FAIL done_pulse_width: done=%b expected 00", done);
    else passed++;
    total++;
    if (req_write[own]) begin
      if ({axi_awvalid, axi_arvalid, axi_awaddr, axi_awlen, axi_awuser_id, axi_awuser_ap} !==
          {1'b1, 1'b0, ad[own], ln[own], exp_id, 1'b1}) begin
        $display("FAIL aw_cmd: vld=%b/%b addr=%h len=%h id=%h ap=%b expected 1/0 %h %h %h 1",
                 axi_awvalid, axi_arvalid, axi_awaddr, axi_awlen, axi_awuser_id, axi_awuser_ap,
                 ad[own], ln[own], exp_id);
      end else passed++;
    end else begin
      if ({axi_awvalid, axi_arvalid, axi_araddr, axi_arlen, axi_aruser_id, axi_aruser_ap} !==
          {1'b0, 1'b1, ad[own], ln[own], exp_id, 1'b1}) begin
        $display("FAIL ar_cmd: vld=%b/%b addr=%h len=%h id=%h ap=%b expected 0/1 %h %h %h 1",
                 axi_awvalid, axi_arvalid, axi_araddr, axi_arlen, axi_aruser_id, axi_aruser_ap,
                 ad[own], ln[own], exp_id);
      end else passed++;
    end
    w = (aw_wait < 0) ? int'($urandom_range(0, 3)) : aw_wait;
    repeat (w) begin
      @(negedge clk); #1;
      total++;
      if ((axi_awvalid | axi_arvalid) !== 1'b1 || axi_awaddr !== ad[own])
        $display("FAIL addr_hold: valid=%b addr=%h expected 1 %h",
                 axi_awvalid | axi_arvalid, axi_awaddr, ad[own]);
      else passed++;
    end
    if (req_write[own]) axi_awready = 1'b1;
    else axi_arready = 1'b1;
    @(negedge clk);
    axi_awready = 1'b0;
    axi_arready = 1'b0;
    #1;
    total++;
    if ({axi_awvalid, axi_arvalid} !== 2'b00)
      $display("FAIL valid_drop: aw/ar=%b%b expected 00", axi_awvalid, axi_arvalid);
    else passed++;
    for (int b = 0; b <= int'(ln[own]); b++) begin
      repeat ($urandom_range(0, 2)) begin
        axi_rdata  = r256();
        axi_rid    = 4'($urandom);
        @(negedge clk);
      end
      d = r256();
      if (req_write[own]) begin
        wd[own]         = d;
        axi_wready      = 1'b1;
        axi_wusero_last = (b == int'(ln[own]));
        #1;
        total++;
        if ({req_wbeat, axi_wdata, axi_wstrb} !== {oh, d, 32'hFFFF_FFFF})
          $display("FAIL wbeat%0d: wbeat=%b wdata=%h strb=%h expected %b %h ffffffff",
                   b, req_wbeat, axi_wdata, axi_wstrb, oh, d);
        else passed++;
        if (abort_beat == b) begin
          rst = 1'b1;
          #1;
          total++;
          if ({axi_awvalid, axi_arvalid, req_wbeat, done, err} !== '0)
            $display("FAIL abort_reset: aw/ar=%b%b wbeat=%b done=%b err=%b expected all 0",
                     axi_awvalid, axi_arvalid, req_wbeat, done, err);
          else passed++;
          axi_wready      = 1'b0;
          axi_wusero_last = 1'b0;
          @(negedge clk);
          rst   = 1'b0;
          m_ptr = 1'b1;
          m_err = 1'b0;
          #1;
          return;
        end
      end else begin
        exp_rl     = (b == int'(ln[own])) ? oh : 2'b00;
        axi_rdata  = d;
        axi_rid    = bad_rid ? 4'd2 : exp_id;
        axi_rvalid = 1'b1;
        axi_rlast  = (b == int'(ln[own]));
        if (bad_rid) m_err = 1'b1;
        #1;
        total++;
        if ({rsp_rvalid, rsp_rlast, rsp_rdata} !== {oh, exp_rl, d})
          $display("FAIL rbeat%0d: rvalid=%b rlast=%b rdata=%h expected %b %b %h",
                   b, rsp_rvalid, rsp_rlast, rsp_rdata, oh, exp_rl, d);
        else passed++;
      end
      @(negedge clk);
      axi_wready      = 1'b0;
      axi_wusero_last = 1'b0;
      axi_rvalid      = 1'b0;
      axi_rlast       = 1'b0;
    end
    #1;
    total++;
    if ({done, err} !== {oh, m_err})
      $display("FAIL burst_done: done=%b err=%b expected %b %b", done, err, oh, m_err);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_write = '0;
    axi_awready = 0; axi_wready = 0; axi_wusero_last = 0; axi_arready = 0;
    axi_rvalid = 0; axi_rlast = 0; axi_rid = '0; axi_rdata = '0;
    for (int i = 0; i < 2; i++) begin wd[i] = '0; ad[i] = '0; ln[i] = '0; end
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({axi_awvalid, axi_arvalid, req_ready, req_wbeat, rsp_rvalid, rsp_rlast, done, err} !== '0)
      $display("FAIL reset_ctrl: aw/ar=%b%b rdy=%b wb=%b rv=%b rl=%b done=%b err=%b expected 0",
               axi_awvalid, axi_arvalid, req_ready, req_wbeat, rsp_rvalid, rsp_rlast, done, err);
    else passed++;
    total++;
    if ({axi_awaddr, axi_awlen, axi_awuser_id, axi_araddr, axi_arlen, axi_aruser_id} !== '0)
      $display("FAIL reset_regs: awaddr=%h awlen=%h awid=%h araddr=%h expected 0",
               axi_awaddr, axi_awlen, axi_awuser_id, axi_araddr);
    else passed++;
    rst   = 1'b0;
    m_ptr = 1'b1;
    m_err = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      total++;
      if ({axi_awvalid, axi_arvalid} !== 2'b00)
        $display("FAIL idle_after_reset: aw/ar=%b%b expected 00", axi_awvalid, axi_arvalid);
      else passed++;
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    for (int i = 0; i < 4; i++) begin
      req_write = 2'($urandom);
      for (int r = 0; r < 2; r++) begin ad[r] = 28'($urandom); ln[r] = 4'($urandom_range(0, 3)); end
      do_burst(2'b11, 1'b0, -1, -1);
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      total++;
      if (obs_grant !== exp_g)
        $display("FAIL contention_order%0d: grant=%b expected %b", i, obs_grant, exp_g);
      else passed++;
    end
    req_valid = '0;
  endtask

  task automatic test_write();
    req_write = 2'b01; ad[0] = 28'h0000100; ln[0] = 4'd1;
    do_burst(2'b01, 1'b0, -1, 3);
  endtask

  task automatic test_read();
    req_write = 2'b00; ad[1] = 28'h0ABCDE0; ln[1] = 4'd3;
    do_burst(2'b10, 1'b0, -1, -1);
  endtask

  task automatic test_error();
    req_write = 2'b00; ad[0] = 28'h0001230; ln[0] = 4'd1;
    do_burst(2'b01, 1'b1, -1, -1);
    req_write = 2'b10; ad[1] = 28'h0004560; ln[1] = 4'd2;
    do_burst(2'b10, 1'b0, -1, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 14; i++) begin
      req_write = 2'($urandom);
      for (int r = 0; r < 2; r++) begin ad[r] = 28'($urandom); ln[r] = 4'($urandom_range(0, 7)); end
      do_burst(2'($urandom_range(1, 3)), 1'b0, -1, -1);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_write();
    req_valid = '0;
    @(negedge clk); #1;
    req_write = 2'b01; ad[0] = 28'h0000200; ln[0] = 4'd3;
    do_burst(2'b01, 1'b0, 0, 1);
    do_burst(2'b01, 1'b0, -1, -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_contention();
    test_write();
    test_read();
    test_error();
    test_random();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
